// File: rtl/pcu_pkg.sv
// Shared encodings and the 2-bit saturating counter step for the next-PC predict unit.
package pcu_pkg;

  localparam logic [2:0] PC_SEL_NONE   = 3'b000;
  localparam logic [2:0] PC_SEL_BRANCH = 3'b001;
  localparam logic [2:0] PC_SEL_JMP    = 3'b010;
  localparam logic [2:0] PC_SEL_JR     = 3'b011;
  localparam logic [2:0] PC_SEL_TRAP   = 3'b100;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_NE = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_GE = 2'b11;

  localparam logic [1:0] CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CTR_STRONG_T = 2'b11;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/pcu_btb.sv
// Direct-mapped branch target buffer: combinational lookup for IF, synchronous
// train/allocate from EX, valid bits cleared by synchronous reset.
module pcu_btb
  import pcu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            upd_en,
  input  logic            upd_is_branch,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             rd_hit, upd_hit;
  logic             unused_pc_lsbs;

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign rd_tag  = rd_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered entry, so a same-cycle update is seen only next cycle.
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken  = rd_hit && ctr_q[rd_idx][1];
  assign rd_target = target_q[rd_idx];
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_en && !upd_hit && upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // NOTE: entry payload is not reset; it is only observable through a set valid bit.
  always_ff @(posedge clk) begin
    if (!reset && upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx]    <= upd_is_branch ? ctr_step(ctr_q[upd_idx], upd_taken) : CTR_STRONG_T;
        target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= upd_is_branch ? CTR_WEAK_T : CTR_STRONG_T;
      end
    end
  end

endmodule

// File: rtl/next_pc_predict_unit.sv
// Fetch PC register with BTB prediction, EX-stage branch/jump/trap resolution,
// mispredict flush/redirect and saturating performance counters.
module next_pc_predict_unit
  import pcu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              BTB_ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080),
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [2:0]       pc_sel,
  input  logic [1:0]       cmp_op,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jmp_target,
  input  logic [XLEN-1:0]  jr_target,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             btb_taken;
  logic [XLEN-1:0]  btb_target;
  logic             cmp_true;
  logic             resolving, is_branch, is_trap, btb_upd;
  logic             actual_taken, mispredict;
  logic [XLEN-1:0]  actual_target, correct_pc;

  pcu_btb #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .reset        (reset),
    .rd_pc        (pc_q),
    .rd_taken     (btb_taken),
    .rd_target    (btb_target),
    .upd_en       (btb_upd),
    .upd_is_branch(is_branch),
    .upd_taken    (actual_taken),
    .upd_pc       (ex_pc),
    .upd_target   (actual_target)
  );

  assign if_pc       = pc_q;
  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : pc_q + PC_STEP;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cmp_true = 1'b0;
    unique case (cmp_op)
      CMP_EQ: cmp_true = (in1 == in2);
      CMP_NE: cmp_true = (in1 != in2);
      CMP_LT: cmp_true = ($signed(in1) <  $signed(in2));
      CMP_GE: cmp_true = ($signed(in1) >= $signed(in2));
    endcase
  end

  always_comb begin
    resolving     = ex_valid;
    actual_taken  = 1'b0;
    actual_target = '0;
    case (pc_sel)
      PC_SEL_BRANCH: begin actual_taken = cmp_true; actual_target = branch_target; end
      PC_SEL_JMP:    begin actual_taken = 1'b1;     actual_target = jmp_target;    end
      PC_SEL_JR:     begin actual_taken = 1'b1;     actual_target = jr_target;     end
      PC_SEL_TRAP:   begin actual_taken = 1'b1;     actual_target = TRAP_VECTOR;   end
      PC_SEL_NONE:   resolving = 1'b0;
      default:       resolving = 1'b0;
    endcase
  end

  assign is_branch  = ex_valid && (pc_sel == PC_SEL_BRANCH);
  assign is_trap    = ex_valid && (pc_sel == PC_SEL_TRAP);
  assign btb_upd    = resolving && !is_trap;
  assign correct_pc = actual_taken ? actual_target : ex_pc + PC_STEP;
  assign mispredict = resolving && (is_trap || (actual_taken != ex_pred_taken) ||
                                    (actual_taken && (actual_target != ex_pred_target)));
  assign flush      = mispredict && !reset;

  // Redirect from EX outranks the IF/ID stall.
  always_comb begin
    pc_d = pred_target;
    if (mispredict)  pc_d = correct_pc;
    else if (stall)  pc_d = pc_q;
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (is_branch && (branch_cnt_q != '1))   branch_cnt_d  = branch_cnt_q + 1'b1;
    if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_next_pc_predict_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// table-based reference model of the predictor.
module tb_next_pc_predict_unit;

  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = 15;
  localparam logic [31:0] TRAP_VEC = 32'h80;

  logic        clk = 1'b0;
  logic        reset, stall, ex_valid, ex_pred_taken;
  logic [31:0] ex_pc, ex_pred_target, in1, in2, branch_target, jmp_target, jr_target;
  logic [2:0]  pc_sel;
  logic [1:0]  cmp_op;
  logic [31:0] if_pc, pred_target;
  logic        pred_taken, flush;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  next_pc_predict_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc_sel(pc_sel), .cmp_op(cmp_op),
    .in1(in1), .in2(in2), .branch_target(branch_target), .jmp_target(jmp_target),
    .jr_target(jr_target), .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  int n_pass = 0;
  int n_total = 0;
  logic last_flush;

  // Reference model: predictor table indexed by word address modulo 16.
  logic [31:0] m_pc;
  bit   [15:0] m_valid;
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  int          m_bcnt, m_mcnt;

  function automatic void m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    int i = int'((pc >> 2) % 16);
    t   = m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
    tgt = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic drive_cycle(input logic rst, input logic st, input logic ev,
                             input logic [31:0] epc, input logic ept, input logic [31:0] etgt,
                             input logic [2:0] sel, input logic [1:0] cop,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt,
                             input string name);
    logic exp_pt, act_taken, mis, resolving, hit;
    logic [31:0] exp_ptgt, act_tgt, correct;
    int j;
    reset = rst; stall = st; ex_valid = ev; ex_pc = epc; ex_pred_taken = ept;
    ex_pred_target = etgt; pc_sel = sel; cmp_op = cop; in1 = a; in2 = b;
    branch_target = bt; jmp_target = jt; jr_target = jrt;
    m_predict(m_pc, exp_pt, exp_ptgt);
    resolving = ev && (sel >= 3'd1) && (sel <= 3'd4);
    act_taken = 1'b0; act_tgt = 32'h0;
    case (sel)
      3'd1: begin
        case (cop)
          2'd0: act_taken = (a == b);
          2'd1: act_taken = (a != b);
          2'd2: act_taken = ($signed(a) < $signed(b));
          default: act_taken = !($signed(a) < $signed(b));
        endcase
        act_tgt = bt;
      end
      3'd2: begin act_taken = 1'b1; act_tgt = jt; end
      3'd3: begin act_taken = 1'b1; act_tgt = jrt; end
      3'd4: begin act_taken = 1'b1; act_tgt = TRAP_VEC; end
      default: ;
    endcase
    mis = resolving && ((sel == 3'd4) || (act_taken != ept) || (act_taken && (act_tgt != etgt)));
    correct = act_taken ? act_tgt : epc + 32'd4;
    #1;
    n_total++;
    if (flush !== (mis && !rst)) $display("FAIL %s flush: got %b want %b", name, flush, mis && !rst);
    else n_pass++;
    last_flush = flush;
    if (!rst) begin
      n_total++;
      if (pred_taken !== exp_pt || pred_target !== exp_ptgt)
        $display("FAIL %s pred at pc %h: got %b/%h want %b/%h", name, m_pc, pred_taken, pred_target, exp_pt, exp_ptgt);
      else n_pass++;
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_valid = '0; m_bcnt = 0; m_mcnt = 0;
    end else begin
      m_pc = mis ? correct : (st ? m_pc : exp_ptgt);
      if (ev && (sel >= 3'd1) && (sel <= 3'd3)) begin
        j   = int'((epc >> 2) % 16);
        hit = m_valid[j] && (m_tag[j] == (epc >> 6));
        if (hit) begin
          if (sel == 3'd1) m_ctr[j] = act_taken ? ((m_ctr[j] < 3) ? m_ctr[j] + 1 : 3)
                                                : ((m_ctr[j] > 0) ? m_ctr[j] - 1 : 0);
          else m_ctr[j] = 3;
          m_tgt[j] = act_tgt;
        end else if (act_taken) begin
          m_valid[j] = 1'b1; m_tag[j] = epc >> 6; m_tgt[j] = act_tgt;
          m_ctr[j] = (sel == 3'd1) ? 2 : 3;
        end
      end
      if (ev && sel == 3'd1 && m_bcnt < CNT_MAX) m_bcnt++;
      if (mis && m_mcnt < CNT_MAX) m_mcnt++;
    end
    #1;
    n_total++;
    if (if_pc !== m_pc || int'(branch_cnt) != m_bcnt || int'(mispred_cnt) != m_mcnt ||
        $isunknown({branch_cnt, mispred_cnt}))
      $display("FAIL %s state: pc %h bcnt %0d mcnt %0d, want pc %h bcnt %0d mcnt %0d",
               name, if_pc, branch_cnt, mispred_cnt, m_pc, m_bcnt, m_mcnt);
    else n_pass++;
  endtask

  task automatic idle(input logic st, input string name);
    drive_cycle(1'b0, st, 1'b0, 0, 1'b0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, name);
  endtask

  task automatic jump_to(input logic [31:0] tgt, input string name);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h104, 3'd2, 2'd0, 0, 0, 0, tgt, 0, name);
  endtask

  task automatic expect_val(input logic [31:0] got, input logic [31:0] want, input string name);
    n_total++;
    if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, "reset0");
    drive_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, "reset1");
    expect_val(if_pc, 32'h0, "reset_pc");
    expect_val({31'h0, pred_taken}, 32'h0, "reset_pred_taken");
    idle(1'b0, "seq0");
    expect_val(if_pc, 32'h4, "seq_pc4");
    idle(1'b0, "seq1");
    expect_val(if_pc, 32'h8, "seq_pc8");
  endtask

  task automatic test_branch_learn();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h14, 3'd1, 2'd0, 5, 5, 32'h40, 0, 0, "beq_taken");
    expect_val({31'h0, last_flush}, 32'h1, "beq_flush");
    expect_val(if_pc, 32'h40, "beq_redirect");
    expect_val({28'h0, mispred_cnt}, 32'h1, "beq_mispred_cnt");
    jump_to(32'h10, "jmp_to_10");
    expect_val({31'h0, pred_taken}, 32'h1, "learned_pred_taken");
    expect_val(pred_target, 32'h40, "learned_pred_target");
  endtask

  task automatic test_not_taken();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 3'd1, 2'd0, 5, 6, 32'h40, 0, 0, "beq_nt1");
    expect_val({31'h0, last_flush}, 32'h1, "nt1_flush");
    expect_val(if_pc, 32'h14, "nt1_redirect");
    jump_to(32'h10, "jmp_to_10b");
    expect_val({31'h0, pred_taken}, 32'h0, "nt1_pred_cleared");
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h14, 3'd1, 2'd0, 5, 6, 32'h40, 0, 0, "beq_nt2");
    expect_val({31'h0, last_flush}, 32'h0, "nt2_no_flush");
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h14, 3'd1, 2'd0, 5, 5, 32'h40, 0, 0, "beq_t_after_sat");
    jump_to(32'h10, "jmp_to_10c");
    expect_val({31'h0, pred_taken}, 32'h0, "ctr_saturated_low");
  endtask

  task automatic test_signed_compare();
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h24, 3'd1, 2'd2, 32'hFFFF_FFFF, 1, 32'h60, 0, 0, "blt");
    expect_val(if_pc, 32'h60, "blt_taken");
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h70, 3'd1, 2'd3, 32'hFFFF_FFFF, 1, 32'h70, 0, 0, "bge");
    expect_val(if_pc, 32'h28, "bge_not_taken");
  endtask

  task automatic test_stall_redirect();
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h50, 1'b0, 32'h54, 3'd3, 2'd0, 0, 0, 0, 0, 32'h200, "jr_stall");
    expect_val(if_pc, 32'h200, "redirect_beats_stall");
    idle(1'b1, "stall_hold0");
    idle(1'b1, "stall_hold1");
    expect_val(if_pc, 32'h200, "stall_holds");
  endtask

  task automatic test_trap();
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h34, 3'd4, 2'd0, 0, 0, 0, 0, 0, "trap_reset");
    expect_val(if_pc, 32'h0, "trap_reset_pc");
    expect_val({28'h0, mispred_cnt}, 32'h0, "trap_reset_cnt");
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h30, 1'b1, 32'h80, 3'd4, 2'd0, 0, 0, 0, 0, 0, "trap");
    expect_val({31'h0, last_flush}, 32'h1, "trap_flush");
    expect_val(if_pc, 32'h80, "trap_vector");
    jump_to(32'h30, "jmp_to_30");
    expect_val({31'h0, pred_taken}, 32'h0, "trap_no_btb");
    expect_val({28'h0, mispred_cnt}, 32'h2, "trap_mispred_cnt");
  endtask

  task automatic test_random();
    logic rst, st, ev, ept;
    logic [31:0] epc, etgt, a, b;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 3) == 0);
      ev  = ($urandom_range(0, 9) < 6);
      epc = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 1) == 1) m_predict(epc, ept, etgt);
      else begin
        ept  = 1'($urandom_range(0, 1));
        etgt = 32'($urandom_range(0, 255)) << 2;
      end
      a = ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFF0 : 32'h0) + 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFF0 : 32'h0) + 32'($urandom_range(0, 3));
      drive_cycle(rst, st, ev, epc, ept, etgt, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  a, b, 32'($urandom_range(0, 255)) << 2, 32'($urandom_range(0, 255)) << 2,
                  32'($urandom_range(0, 255)) << 2, "random");
    end
  endtask

  initial begin
    m_pc = 32'h0; m_valid = '0; m_bcnt = 0; m_mcnt = 0;
    test_reset();
    test_branch_learn();
    test_not_taken();
    test_signed_compare();
    test_stall_redirect();
    test_trap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/next_pc_predict_unit.md
Name: next_pc_predict_unit

Overview:
- Parametrised successor to the combinational branch/jump decision logic.
- Owns the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The BTB predicts the next PC in IF.
- Resolves branch/jump/jr/trap in EX and issues a one-cycle flush plus redirect on a mispredict.
- Sits between the IF stage (PC output) and the EX stage (resolution inputs).

Parameters:
- XLEN, 32, PC and operand width.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC on reset.
- TRAP_VECTOR, 32'h0000_0080, target for pc_sel=TRAP.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold if_pc (IF/ID stall).
- if_pc  out  XLEN  current fetch PC.
- pred_taken  out  1  BTB predicts taken for if_pc.
- pred_target  out  XLEN  predicted target; equals if_pc+4 when not predicted taken.
- ex_valid  in  1  EX holds a valid control-transfer instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_pred_taken  in  1  pred_taken carried down the pipeline.
- ex_pred_target  in  XLEN  pred_target carried down the pipeline.
- pc_sel  in  3  000 NONE, 001 BRANCH, 010 JMP, 011 JR, 100 TRAP; other codes are treated as NONE.
- cmp_op  in  2  00 EQ, 01 NE, 10 LT (signed), 11 GE (signed).
- in1, in2  in  XLEN  branch comparison operands.
- branch_target, jmp_target, jr_target  in  XLEN  resolved targets.
- flush  out  1  kill the IF and ID instructions this cycle.
- branch_cnt, mispred_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset values:
  - if_pc = RESET_VECTOR.
  - All BTB valid bits = 0.
  - All counters = 0.
  - flush = 0 while reset is high.
  - pred_taken = 0.
- BTB indexing: index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[XLEN-1:log2(BTB_ENTRIES)+2].
- BTB entry fields: valid, tag, target, ctr[1:0].
- IF lookup (combinational on if_pc):
  - A hit requires the entry valid and the tag equal.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? entry.target : if_pc+4.
  - Arithmetic is modulo 2^XLEN.
- EX resolution, when ex_valid and pc_sel≠NONE:
  - actual_taken: BRANCH = compare(cmp_op) on in1/in2; JMP/JR/TRAP = 1.
  - actual_target: BRANCH/JMP/JR use the matching target input; TRAP uses TRAP_VECTOR.
  - correct_pc = actual_taken ? actual_target : ex_pc+4.
  - mispredict = (actual_taken≠ex_pred_taken) | (actual_taken & actual_target≠ex_pred_target).
  - TRAP always counts as a mispredict.
  - flush = mispredict, combinational, same cycle.
- Next-PC priority, evaluated each edge:
  - reset
  - > EX mispredict (if_pc←correct_pc, overrides stall)
  - > stall (hold)
  - > pred_target.
- BTB update, at the edge when ex_valid and pc_sel∈{BRANCH, JMP, JR}:
  - Tag hit: BRANCH increments ctr (saturating at 11) if taken, decrements (saturating at 00) if not. JMP/JR set ctr=11. target←actual_target.
  - Tag miss and actual_taken: allocate (overwrite), valid=1, tag, target, ctr = BRANCH ? 10 : 11.
  - Tag miss and not taken: no change.
- TRAP never updates the BTB.
- Read-before-write: an IF lookup in the same cycle as an update to the same index sees the old entry.
- Update and redirect are independent of stall.
- Counters:
  - branch_cnt increments on each resolved BRANCH.
  - mispred_cnt increments on each mispredict of any type.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-operation wins over every other event in that cycle; no BTB update occurs that cycle.

Decomposition:
- Package pcu_pkg holds:
  - PC_SEL_* codes (3-bit).
  - CMP_* codes (2-bit).
  - CTR_WEAK_T=2'b10, CTR_STRONG_T=2'b11.
  - Saturating increment/decrement function for the 2-bit counter.
- One sub-module, pcu_btb:
  - Entry storage, combinational lookup port, synchronous update port, synchronous clear on reset.
- Top level holds the PC register, resolution/compare logic, priority mux and performance counters.

Test Plan:
- Reset for 2 cycles, then release with no EX activity → if_pc=0x0, 0x4, 0x8 on successive cycles; pred_taken=0; flush never asserted.
- BEQ at ex_pc=0x10, in1=in2=5, target 0x40, ex_pred_taken=0 → flush=1 that cycle; next if_pc=0x40; mispred_cnt=1. When if_pc later reaches 0x10 → pred_taken=1 (ctr=10), pred_target=0x40.
- Same branch resolved not-taken twice (in1=5, in2=6) → first resolution: ctr 10→01, flush=1, redirect to 0x14. Next lookup of 0x10 gives pred_taken=0. A further not-taken resolution saturates ctr at 00.
- Signed compare: BLT with in1=0xFFFF_FFFF, in2=1 → taken. BGE with the same operands → not taken, redirect to ex_pc+4 if predicted taken.
- stall=1 together with a JR mispredict to 0x200 → if_pc=0x200 next cycle (redirect beats stall). stall=1 alone → if_pc holds.
- TRAP at ex_pc=0x30 and reset asserted in the same cycle → if_pc=RESET_VECTOR, no BTB change. TRAP without reset → if_pc=0x80, flush=1, BTB unchanged.
